if_pc_unit: RTL
===============

# if_pc_unit

Instruction-fetch stage program-counter unit for the five-stage MIPS pipeline. It holds the fetch PC and advances it by 4 each cycle. It applies redirects from branch/jump resolution in ID, exception entry and `eret` from CP0. It flags fetch-address errors for the IF/ID register. A one-entry pending-redirect register keeps a taken branch that resolves while fetch is stalled, so the redirect is not lost.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_3000, PC loaded on reset.
- `HANDLER_PC`, 32'h0000_4180, exception/interrupt entry address.
- `IM_BASE`, 32'h0000_3000, lowest legal fetch address.
- `IM_TOP`, 32'h0000_6ffc, highest legal fetch address (inclusive).

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low; sampled on rising `clk`.
- `PCStall`  in  1  hold fetch PC; driven by the same hazard logic as the IF/ID stall.
- `BranchTaken`  in  1  ID-stage branch/jump resolved taken this cycle.
- `BranchTarget`  in  32  target for `BranchTaken`.
- `ExcReq`  in  1  CP0 takes an exception or interrupt this cycle.
- `EretReq`  in  1  `eret` commits this cycle.
- `EPC`  in  32  return address for `EretReq`.
- `IFPC`  out  32  current fetch address, registered; drives instruction memory and IF/ID.
- `IFPCError`  out  1  combinational fetch-address error for `IFPC`.
- `IFRedirectPending`  out  1  registered; high while a branch redirect is held.

## Operation

- State: `IFPC`, a 1-bit FSM (`IDLE`/`PEND`) and a 32-bit `PendTarget`.
- Next-PC priority, highest first:
  1. `ExcReq`: PC <= `HANDLER_PC`.
  2. `EretReq`: PC <= `EPC`.
  3. `BranchTaken` with `PCStall`=0: PC <= `BranchTarget`.
  4. `PEND` with `PCStall`=0: PC <= `PendTarget`.
  5. `PCStall`=0: PC <= PC+4.
  6. Otherwise hold.
- `ExcReq` and `EretReq` ignore `PCStall`. They always load and force `IDLE`, discarding any pending target.
- FSM rules:
  - In `IDLE`, `BranchTaken` while `PCStall`=1 captures `BranchTarget` into `PendTarget`, goes to `PEND`, and holds the PC.
  - In `PEND`, `PCStall`=0 loads `PendTarget` and returns to `IDLE`. If `BranchTaken` is also high, `BranchTarget` wins and the state still returns to `IDLE`.
  - In `PEND`, `BranchTaken` while `PCStall`=1 overwrites `PendTarget` and stays in `PEND`.
  - `ExcReq` and `EretReq` send both states to `IDLE`.
- `ExcReq` and `EretReq` both high: `ExcReq` wins.
- `IFPCError` = (`IFPC[1:0]` != 0) | (`IFPC` < `IM_BASE`) | (`IFPC` > `IM_TOP`). Compares are unsigned, 32-bit.
- PC+4 is a 32-bit modulo add: 32'hFFFF_FFFC wraps to 0, and that address is flagged.
- Illegal `EPC` or `BranchTarget` values load unchanged. The error shows only through `IFPCError`; there is no internal trap.
- `IFRedirectPending` = (state == `PEND`).

## Timing

- Reset (`reset`=0 at a rising edge): `IFPC`=`RESET_PC`, state `IDLE`, `PendTarget`=0, `IFRedirectPending`=0. `IFPCError` reflects `RESET_PC` (0 with default parameters). Reset overrides every other input.
- A reset deasserted mid-`PEND` never loads the pending target.
- Redirect latency: one cycle. A request sampled at edge N makes `IFPC` show the new address after edge N.
- The branch delay slot is the instruction at `IFPC` during the cycle `BranchTaken` is high. That instruction is not cancelled by this block.
- Stall release from `PEND`: the cycle after `PCStall` falls, `IFPC`=`PendTarget`. There is no PC+4 step in between.
- `IFPCError` has zero latency from `IFPC`. No combinational path runs from any input to `IFPC` or `IFRedirectPending`.

## Test plan

- **Reset and increment.** Hold `reset`=0 for 2 cycles, then 1 with no requests: `IFPC` reads 3000, 3004, 3008, 300c; `IFPCError`=0.
- **Stalled branch.** At PC 3010, `PCStall`=1 for 3 cycles, with `BranchTaken`=1 and target 3100 in the first of them. Required: PC holds at 3010 and `IFRedirectPending`=1. After the stall releases, PC reads 3100 and then 3104.
- **Exception during a pending redirect.** In `PEND` (target 3100), with `PCStall`=1, assert `ExcReq`: next `IFPC`=4180, `IFRedirectPending`=0. After the stall releases, PC reads 4184, not 3100.
- **Simultaneous requests.** Assert `ExcReq`, `EretReq` (`EPC`=3200) and `BranchTaken` (target 3300) together: `IFPC`=4180. Then `EretReq` alone with `EPC`=3202: `IFPC`=3202 and `IFPCError`=1.
- **Address range.** Branch to 6ffc: error 0, then PC 7000 with error 1. Branch to 2ffc: error 1. Branch to FFFFFFFC, then release: PC wraps to 0 and error stays 1.
- **Reset while pending.** In `PEND`, assert `reset`=0: `IFPC`=3000 and `IFRedirectPending`=0. After release, PC reads 3004 with no jump to the old target.

Source files
------------

// File: rtl/if_pc_unit.sv
// Fetch-stage PC: advances by 4, applies exception/eret/branch redirects, parks a branch seen under stall.
// Latency: redirects visible one cycle after sampling; PCStall holds the PC but never drops a taken branch.
module if_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_TOP     = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCStall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        ExcReq,
  input  logic        EretReq,
  input  logic [31:0] EPC,
  output logic [31:0] IFPC,
  output logic        IFPCError,
  output logic        IFRedirectPending
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pend_target;
  logic [31:0] pend_target_nxt;
  logic [31:0] pc_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      IFPC        <= RESET_PC;
      state       <= IDLE;
      pend_target <= '0;
    end else begin
      IFPC        <= pc_nxt;
      state       <= state_nxt;
      pend_target <= pend_target_nxt;
    end
  end

  always_comb begin
    pc_nxt          = IFPC;
    state_nxt       = state;
    pend_target_nxt = pend_target;
    if (ExcReq) begin
      pc_nxt    = HANDLER_PC;
      state_nxt = IDLE;
    end else if (EretReq) begin
      pc_nxt    = EPC;
      state_nxt = IDLE;
    end else if (!PCStall) begin
      // A fresh branch outranks the parked one; either way the slot is consumed.
      if (BranchTaken)
        pc_nxt = BranchTarget;
      else if (state == PEND)
        pc_nxt = pend_target;
      else
        pc_nxt = IFPC + 32'd4;
      state_nxt = IDLE;
    end else if (BranchTaken) begin
      pend_target_nxt = BranchTarget;
      state_nxt       = PEND;
    end
  end

  assign IFPCError = (IFPC[1:0] != 2'b00) | (IFPC < IM_BASE) | (IFPC > IM_TOP);
  assign IFRedirectPending = (state == PEND);

endmodule
